// File: rtl/servant_uart_rx.sv
// ---------------------------------------------------------------------------
// servant_uart_rx
//
// Polled 8N1 UART receiver for the servant SoC. The serial line is
// synchronised, framed by a small FSM, and received bytes are buffered for
// SERV firmware, which reads them over a two-register Wishbone slave.
//
// Build option:
//   SERVANT_UART_RX_FIFO_EN  defined   -> receive FIFO of 2**FIFO_AW bytes
//                            undefined -> single holding register (depth 1)
//
// Parameters:
//   CLKS_PER_BIT  i_clk cycles per bit period (>= 8)
//   FIFO_AW       log2 of FIFO depth (FIFO build only)
//
// Ports:
//   i_clk      wb_clk system clock
//   i_rst_n    asynchronous active-low reset
//   i_rx       asynchronous serial input, idle high
//   i_wb_adr   0 = DATA, 1 = STATUS
//   i_wb_cyc   bus cycle request
//   i_wb_we    write enable (writes are acknowledged and ignored)
//   o_wb_rdt   registered read data, valid while o_wb_ack is high
//   o_wb_ack   single-cycle registered acknowledge
//
// STATUS layout: [8:4] count, [3] 0, [2] fe, [1] ovr, [0] data valid.
// ---------------------------------------------------------------------------
module servant_uart_rx #(
    parameter int CLKS_PER_BIT = 139,
    parameter int FIFO_AW      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx,
    input  logic        i_wb_adr,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rx_meta;
    logic             rxs;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    logic             bit_sample;
    logic             stop_sample;
    logic             cnt_clr;

    logic             push_req;
    logic             frame_err;
    logic             full;
    logic             empty;
    logic [7:0]       head;
    logic [FIFO_AW:0] count;
    logic             do_push;
    logic             do_pop;
    logic             ovr_set;

    logic             bus_stb;
    logic             rd_stb;
    logic             data_rd;
    logic             status_rd;
    logic             ovr;
    logic             fe;
    logic [4:0]       status_cnt;
    logic [31:0]      status_word;

    // Two-flop synchroniser; resets to the idle (high) line level so reset
    // release never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rxs     <= rx_meta;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. STOP returns to IDLE on the sample cycle itself so a
    // start bit immediately following the stop bit is not missed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!rxs) state_nxt = START;
            START: if (cnt == HALF_M1) state_nxt = rxs ? IDLE : DATA;
            DATA:  if (cnt == FULL_M1 && bit_idx == 3'd7) state_nxt = STOP;
            STOP:  if (cnt == FULL_M1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: sampling strobes and the bit-counter reload. After the
    // half-bit start sample, every full-period wrap lands on mid-bit.
    always_comb begin
        bit_sample  = 1'b0;
        stop_sample = 1'b0;
        cnt_clr     = 1'b0;
        case (state)
            IDLE:  cnt_clr = 1'b1;
            START: cnt_clr = (cnt == HALF_M1);
            DATA: begin
                bit_sample = (cnt == FULL_M1);
                cnt_clr    = (cnt == FULL_M1);
            end
            STOP: begin
                stop_sample = (cnt == FULL_M1);
                cnt_clr     = (cnt == FULL_M1);
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    // Bit timing counter, bit index and LSB-first shift register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
            if (state == IDLE) begin
                bit_idx <= '0;
            end else if (bit_sample) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (bit_sample) begin
                shreg <= {rxs, shreg[7:1]};
            end
        end
    end

    assign push_req  = stop_sample & rxs;
    assign frame_err = stop_sample & ~rxs;

    // A bus request is accepted only on the cycle before the ack, so each
    // transaction pops or clears exactly once.
    assign bus_stb   = i_wb_cyc & ~o_wb_ack;
    assign rd_stb    = bus_stb & ~i_wb_we;
    assign data_rd   = rd_stb & ~i_wb_adr;
    assign status_rd = rd_stb & i_wb_adr;

    // Fullness is judged before any same-cycle pop, so a push into a full
    // buffer is always an overrun.
    assign do_push = push_req & ~full;
    assign do_pop  = data_rd & ~empty;
    assign ovr_set = push_req & full;

`ifdef SERVANT_UART_RX_FIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage array has no reset; its contents are only read when count > 0
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end
`else
    logic [7:0] hold;
    logic       hold_valid;

    assign full  = hold_valid;
    assign empty = ~hold_valid;
    assign head  = hold;
    assign count = {{FIFO_AW{1'b0}}, hold_valid};

    // Single holding register; an arriving byte while holding is dropped
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (do_push) begin
            hold       <= shreg;
            hold_valid <= 1'b1;
        end else if (do_pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    assign status_cnt  = 5'(count);
    assign status_word = {23'h0, status_cnt, 1'b0, fe, ovr, ~empty};

    // Bus response and sticky flags. A set event wins over a clearing read
    // in the same cycle so no error is ever lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
            ovr      <= 1'b0;
            fe       <= 1'b0;
        end else begin
            o_wb_ack <= bus_stb;
            if (bus_stb) begin
                if (i_wb_we) begin
                    o_wb_rdt <= '0;
                end else if (i_wb_adr) begin
                    o_wb_rdt <= status_word;
                end else begin
                    o_wb_rdt <= {24'h0, empty ? 8'h00 : head};
                end
            end
            ovr <= ovr_set   | (ovr & ~status_rd);
            fe  <= frame_err | (fe  & ~status_rd);
        end
    end

endmodule

// File: doc/servant_uart_rx.md
# servant_uart_rx

Wishbone-polled UART receiver for the servant SoC on the Tang Nano 20K, the receive counterpart to the GPIO-driven `o_uart_tx` path. It samples an asynchronous 8N1 serial line and frames bytes. It buffers the bytes and presents them to SERV firmware through a two-register Wishbone slave on the `wb_clk` domain. Firmware polls status and pops bytes. No interrupts.

## Interface
- `CLKS_PER_BIT`, default 139: `i_clk` cycles per bit period; must be ≥ 8.
- `FIFO_AW`, default 2: log2 of the receive FIFO depth, used only when the FIFO is compiled in.
- `i_clk` in, 1 bit: the `wb_clk` system clock.
- `i_rst_n` in, 1 bit: asynchronous, active-low reset.
- `i_rx` in, 1 bit: serial input, asynchronous, idle high.
- `i_wb_adr` in, 1 bit: 0 selects DATA, 1 selects STATUS.
- `i_wb_cyc` in, 1 bit: bus cycle request.
- `i_wb_we` in, 1 bit: write enable. Writes are acknowledged and ignored.
- `o_wb_rdt` out, 32 bits: read data.
- `o_wb_ack` out, 1 bit: single-cycle acknowledge.

## Operation
- **Input synchronizer:** `i_rx` passes through a 2-flop synchronizer. Its flops reset to 1. All logic uses the synchronized value `rxs`.
- **States:** IDLE, START, DATA, STOP. A bit counter `cnt` runs 0..CLKS_PER_BIT-1. A bit index runs 0..7.
- **IDLE:** `rxs`==0 → START with `cnt`=0.
- **START:** at `cnt`==CLKS_PER_BIT/2-1 (integer divide), sample `rxs`.
  - `rxs`==1: false start, return to IDLE. No flags are set.
  - `rxs`==0: go to DATA and reload `cnt`.
- **DATA:** sample every CLKS_PER_BIT cycles at mid-bit. Bits shift into the shift register LSB first. After bit 7 go to STOP.
- **STOP:** sample at mid-stop-bit, then return to IDLE the same cycle so a back-to-back start bit is caught.
  - Sample is 1: push the byte. If the FIFO is full, drop the byte and set `ovr`.
  - Sample is 0: set `fe` and discard the byte.
- **FIFO:** depth 2^FIFO_AW, circular pointers that wrap at depth, occupancy count 0..depth.
  - A push and a pop in the same cycle both happen; the count is unchanged.
  - Full is evaluated on the pre-pop count. A push while full is an overrun even if a pop happens the same cycle.
- **DATA read (adr 0):** `o_wb_rdt`={24'h0, head byte} and the FIFO pops. An empty FIFO returns 0 and does not pop.
- **STATUS read (adr 1):** `o_wb_rdt` = {zeros, count[FIFO_AW:0] at [8:4], 0 at [3], `fe` at [2], `ovr` at [1], `!empty` at [0]}.
  - `ovr` and `fe` are sticky and clear on a STATUS read.
  - A set event and a clearing read in the same cycle leave the flag set.
- **Reset:** state IDLE, `cnt`=0, FIFO empty, pointers 0, `ovr`=`fe`=0, `o_wb_ack`=0, `o_wb_rdt`=0. Reset asserted mid-frame aborts the frame and drops the partial byte.

## Timing
- `o_wb_ack` is registered: `o_wb_ack` <= `i_wb_cyc` & !`o_wb_ack`. It asserts exactly one cycle after `i_wb_cyc` rises, lasts one cycle, and is never back-to-back.
- `o_wb_rdt` is registered and valid in the ack cycle. The pop and the flag clear take effect on the ack edge, once per transaction.
- Line to `rxs`: 2 cycles.
- The falling edge of the start bit to the stop sample is 9.5 bit periods plus 2 cycles.
- The byte is visible (`!empty`) on the cycle after the stop-sample edge.
- Tolerates a baud mismatch of ±4% between sender and `CLKS_PER_BIT`.

## Configuration
- Macro `SERVANT_UART_RX_FIFO_EN`.
- **Defined:** FIFO of 2^FIFO_AW entries as described above.
- **Undefined:** single holding register, depth 1.
  - Count is 0 or 1 and STATUS[8:5] read as 0.
  - A push while the register is holding sets `ovr` and keeps the old byte.
  - `FIFO_AW` is ignored.

## Test plan
(Bench uses CLKS_PER_BIT=16 and the FIFO compiled in with FIFO_AW=2.)
- **Single byte:** send 0xA5 8N1, then read STATUS → 0x011. Read DATA → 0x000000A5. Read STATUS → 0x000.
- **False start:** a low glitch of 5 cycles (under half a bit) → state back to IDLE, STATUS stays 0x000.
- **Framing error:** send 0x3C with stop bit 0 → STATUS 0x004 (fe set, empty). A second STATUS read → 0x000.
- **Overrun and wrap:** send 0x01..0x05 back-to-back with no reads → STATUS 0x043 (count 4, ovr, valid). Reads return 01, 02, 03, 04. After a pop, send 0x06 and 0x07 so the pointers wrap; reads return 06, 07.
- **Simultaneous events:** a DATA read on the same edge as a push into a 1-entry FIFO → count stays 1, popped byte correct. A STATUS read on the `fe` set edge → `fe` remains set.
- **Reset mid-frame:** pull `i_rst_n` low during bit 4 of 0xFF, then release → all outputs 0, FIFO empty. The next byte, 0x5A, is received correctly.
